// File: rtl/skew_inbuf.sv
// Multi-lane skewed input buffer. Every lane is a circular FIFO that is written
// and read as part of one vector. On reset or clear, lane i is preloaded with
// i*SKEW zero entries, so the array behind it sees diagonally skewed operands.
module skew_inbuf #(
  parameter int unsigned WORDLEN = 8,
  parameter int unsigned NLANES  = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned SKEW    = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clear,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [NLANES*WORDLEN-1:0]   din,
  input  logic                        rd_en,
  output logic [NLANES*WORDLEN-1:0]   dout,
  output logic [NLANES-1:0]           lane_empty,
  output logic                        all_empty,
  output logic                        ovf,
  output logic                        udf
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]      head_q [NLANES];
  logic [PW-1:0]      head_d [NLANES];
  logic [PW-1:0]      tail_q [NLANES];
  logic [PW-1:0]      tail_d [NLANES];
  logic [CW-1:0]      cnt_q  [NLANES];
  logic [CW-1:0]      cnt_d  [NLANES];
  logic [WORDLEN-1:0] mem_q  [NLANES][DEPTH];
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic [NLANES-1:0]  lane_full;
  logic [NLANES-1:0]  pop;
  logic               wr_fire;

  // Wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status flags and first-word-fall-through head words, all from registered state.
  always_comb begin
    dout       = '0;
    lane_empty = '0;
    lane_full  = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      lane_empty[i] = (cnt_q[i] == '0);
      lane_full[i]  = (cnt_q[i] == CW'(DEPTH));
      if (!lane_empty[i]) begin
        dout[i*WORDLEN +: WORDLEN] = mem_q[i][head_q[i]];
      end
    end
    wr_ready  = ~|lane_full;
    all_empty = &lane_empty;
    ovf       = ovf_q;
    udf       = udf_q;
  end

  // Next-state for pointers, counts and sticky flags; clear overrides rd/wr.
  always_comb begin
    wr_fire = wr_valid & wr_ready;
    pop     = '0;
    ovf_d   = ovf_q | (wr_valid & ~wr_ready);
    udf_d   = udf_q | (rd_en & all_empty);
    for (int unsigned i = 0; i < NLANES; i++) begin
      head_d[i] = head_q[i];
      tail_d[i] = tail_q[i];
      cnt_d[i]  = cnt_q[i];
      pop[i]    = rd_en & ~lane_empty[i];
      if (clear) begin
        head_d[i] = '0;
        tail_d[i] = PW'(i * SKEW);
        cnt_d[i]  = CW'(i * SKEW);
      end else begin
        if (pop[i]) head_d[i] = ptr_inc(head_q[i]);
        if (wr_fire) tail_d[i] = ptr_inc(tail_q[i]);
        if (wr_fire && !pop[i]) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else if (!wr_fire && pop[i]) begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
    if (clear) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  // Pointer, count and flag registers; reset restores the padded state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NLANES; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= PW'(i * SKEW);
        cnt_q[i]  <= CW'(i * SKEW);
      end
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NLANES; i++) begin
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Lane storage; zeroed on reset/clear so the padding entries read as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NLANES; i++) begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else if (clear) begin
      for (int unsigned i = 0; i < NLANES; i++) begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else if (wr_fire) begin
      for (int unsigned i = 0; i < NLANES; i++) begin
        mem_q[i][tail_q[i]] <= din[i*WORDLEN +: WORDLEN];
      end
    end
  end

endmodule
